// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with private HI/LO registers.
// Fixed-latency md ops, single-cycle mthi/mtlo, cancellable in flight.
module mdu_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_op;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;

    logic              w_run;
    logic              w_last;
    logic              w_accept;
    logic              w_mt_we;
    logic              w_commit;
    logic              w_b_zero;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [2*WIDTH-1:0] w_ma;
    logic [2*WIDTH-1:0] w_mb;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]  w_num;
    logic [WIDTH-1:0]  w_den;
    logic [WIDTH-1:0]  w_q;
    logic [WIDTH-1:0]  w_r;
    logic [WIDTH-1:0]  w_quo;
    logic [WIDTH-1:0]  w_rem;
    logic [WIDTH-1:0]  w_res_hi;
    logic [WIDTH-1:0]  w_res_lo;
    logic              w_res_we;

    // Request decode: an md op may be accepted in IDLE or on the completion edge
    always_comb begin
        w_run    = (r_state == S_RUN);
        w_last   = w_run && (r_cnt == (r_op[1] ? DIV_LAST : MUL_LAST));
        w_accept = start && !cancel && !op[2] && (!w_run || w_last);
        w_mt_we  = start && !cancel && op[2] && !op[1] && !w_run;
        w_commit = w_last && !cancel && w_res_we;
    end

    // Result datapath from latched operands; one multiplier serves both signednesses
    always_comb begin
        w_ma = r_op[0] ? {{WIDTH{1'b0}}, r_a} : {{WIDTH{r_a[WIDTH-1]}}, r_a};
        w_mb = r_op[0] ? {{WIDTH{1'b0}}, r_b} : {{WIDTH{r_b[WIDTH-1]}}, r_b};
        w_prod = w_ma * w_mb;
        w_b_zero = (r_b == '0);
        w_neg_a  = !r_op[0] && r_a[WIDTH-1];
        w_neg_b  = !r_op[0] && r_b[WIDTH-1];
        w_num    = w_neg_a ? -r_a : r_a;
        w_den    = w_b_zero ? WIDTH'(1) : (w_neg_b ? -r_b : r_b);
        w_q      = w_num / w_den;
        w_r      = w_num % w_den;
        w_quo    = (w_neg_a ^ w_neg_b) ? -w_q : w_q;
        w_rem    = w_neg_a ? -w_r : w_r;
        w_res_hi = r_op[1] ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = r_op[1] ? w_quo : w_prod[WIDTH-1:0];
        w_res_we = !(r_op[1] && w_b_zero);
    end

    // Next-state and busy; cancel beats completion and any back-to-back start
    always_comb begin
        w_next = r_state;
        busy   = w_run;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_RUN;
            end
            S_RUN: begin
                if (cancel) w_next = S_IDLE;
                else if (w_last) w_next = w_accept ? S_RUN : S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Cycle counter: restarts on accept, cleared whenever idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                r_cnt <= '0;
        else if (w_accept)         r_cnt <= '0;
        else if (w_next == S_RUN)  r_cnt <= r_cnt + CW'(1);
        else                       r_cnt <= '0;
    end

    // Operand and op capture at the accept edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op <= '0;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_accept) begin
            r_op <= op[1:0];
            r_a  <= a;
            r_b  <= b;
        end
    end

    // HI/LO update on md completion or mthi/mtlo
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (w_mt_we) begin
            if (op[0]) r_lo <= a;
            else       r_hi <= a;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
